// File: rtl/rx78_pkg.sv
// rx78_pkg: shared interrupt bit indices, register offsets and divider rate table
package rx78_pkg;
    localparam int IRQ_VB = 0;
    localparam int IRQ_KB = 1;
    localparam logic [7:0] REG_RATE   = 8'd0;
    localparam logic [7:0] REG_CTRL   = 8'd1;
    localparam logic [7:0] REG_STATUS = 8'd2;
    localparam logic [23:0] DEF_RATE_TABLE = {6'd63, 6'd7, 6'd3, 6'd0};
endpackage

// File: rtl/rx_irq_divider.sv
// rx_irq_divider: rising-edge detector plus modulo counter, pulsing tick_o once every limit_i+1 edges
module rx_irq_divider #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         cen_i,
    input  logic         en_i,
    input  logic         restart_i,
    input  logic         vb_i,
    input  logic [W-1:0] limit_i,
    output logic         tick_o
);
    logic         vb_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic         rise, hit;

    always_comb begin
        rise   = vb_i & ~vb_q;
        hit    = cnt_q == limit_i;
        tick_o = cen_i & en_i & rise & hit & ~restart_i;
        cnt_d  = restart_i ? '0 : (en_i & rise) ? (hit ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vb_q  <= 1'b0;
            cnt_q <= '0;
        end else if (cen_i) begin
            vb_q  <= vb_i;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rx_irq_ctrl.sv
// rx_irq_ctrl: RX-78 vblank/keyboard interrupt controller with I/O-mapped rate, ctrl and W1C status
module rx_irq_ctrl
    import rx78_pkg::*;
#(
    parameter int KB_W   = 8,
    parameter int DIV_W  = 6,
    parameter int RATE_W = 2,
    parameter logic [DIV_W*(2**RATE_W)-1:0] RATE_TABLE = DEF_RATE_TABLE,
    parameter logic [7:0] IO_BASE = 8'hF3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            cen_i,
    input  logic            io_wr_i,
    input  logic            io_rd_i,
    input  logic [7:0]      io_addr_i,
    input  logic [7:0]      io_din_i,
    output logic [7:0]      io_dout_o,
    input  logic            vb_i,
    input  logic [KB_W-1:0] kb_rows_i,
    input  logic            kb_mode_i,
    input  logic            int_ack_i,
    output logic            int_n_o,
    output logic [1:0]      pending_o
);
    localparam logic [7:0] A_RATE = IO_BASE + REG_RATE;
    localparam logic [7:0] A_CTRL = IO_BASE + REG_CTRL;
    localparam logic [7:0] A_STAT = IO_BASE + REG_STATUS;

    logic [RATE_W-1:0] rate_q;
    logic [1:0]        ctrl_q, pending_q, pending_d, set, clr;
    logic [KB_W-1:0]   kb_q;
    logic [7:0]        io_dout_q, rd_d;
    logic              int_n_q, wr_rate, wr_ctrl, wr_stat, kb_set, tick;
    logic [DIV_W-1:0]  limit;
    logic              unused_din;

    assign unused_din = ^io_din_i;

    rx_irq_divider #(.W(DIV_W)) u_div (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cen_i     (cen_i),
        .en_i      (~kb_mode_i & ctrl_q[IRQ_VB]),
        .restart_i (wr_rate),
        .vb_i      (vb_i),
        .limit_i   (limit),
        .tick_o    (tick)
    );

    always_comb begin
        wr_rate   = io_wr_i & (io_addr_i == A_RATE);
        wr_ctrl   = io_wr_i & (io_addr_i == A_CTRL);
        wr_stat   = io_wr_i & (io_addr_i == A_STAT);
        limit     = RATE_TABLE[rate_q*DIV_W +: DIV_W];
        kb_set    = kb_mode_i & ctrl_q[IRQ_KB] & (|kb_rows_i) & (kb_rows_i != kb_q);
        set       = {kb_set, tick};
        clr       = {2{int_ack_i}} | (wr_stat ? io_din_i[1:0] : 2'b00);
        // set is OR-ed in after the clear so a same-cycle event always survives
        pending_d = (pending_q & ~clr) | set;
        rd_d      = (io_addr_i == A_RATE) ? 8'(rate_q) :
                    (io_addr_i == A_CTRL) ? {6'b0, ctrl_q} :
                    (io_addr_i == A_STAT) ? {6'b0, pending_q} : 8'hFF;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rate_q    <= '0;
            ctrl_q    <= 2'b11;
            pending_q <= 2'b00;
            kb_q      <= '0;
            io_dout_q <= 8'hFF;
            int_n_q   <= 1'b1;
        end else if (cen_i) begin
            if (wr_rate) rate_q <= io_din_i[RATE_W-1:0];
            if (wr_ctrl) ctrl_q <= io_din_i[1:0];
            if (io_rd_i) io_dout_q <= rd_d;
            pending_q <= pending_d;
            kb_q      <= kb_rows_i;
            int_n_q   <= ~|(pending_q & ctrl_q);
        end
    end

    assign io_dout_o = io_dout_q;
    assign int_n_o   = int_n_q;
    assign pending_o = pending_q;
endmodule

// File: tb/tb_rx_irq_ctrl.sv
// tb_rx_irq_ctrl: directed scenario bench for rx_irq_ctrl
module tb_rx_irq_ctrl;
    logic       clk = 0, reset = 1, cen = 1, io_wr = 0, io_rd = 0;
    logic [7:0] io_addr = 0, io_din = 0, io_dout, kb_rows = 0, rd;
    logic       vb = 0, kb_mode = 0, int_ack = 0, int_n;
    logic [1:0] pending;
    int tests = 0, fails = 0;

    rx_irq_ctrl dut (
        .clk_i(clk), .reset_i(reset), .cen_i(cen), .io_wr_i(io_wr), .io_rd_i(io_rd),
        .io_addr_i(io_addr), .io_din_i(io_din), .io_dout_o(io_dout), .vb_i(vb),
        .kb_rows_i(kb_rows), .kb_mode_i(kb_mode), .int_ack_i(int_ack),
        .int_n_o(int_n), .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic cyc(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io_wr = 1; io_addr = a; io_din = d; cyc(); io_wr = 0;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        io_rd = 1; io_addr = a; cyc(); io_rd = 0; d = io_dout;
    endtask

    task automatic ack();
        int_ack = 1; cyc(); int_ack = 0;
    endtask

    task automatic test_reset();
        reset = 1; cyc(2); reset = 0;
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL reset_pending got %b exp 00", pending); end
        tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL reset_int_n got %b exp 1", int_n); end
        tests++; if (io_dout !== 8'hFF) begin fails++; $display("FAIL reset_dout got %h exp ff", io_dout); end
        io_read(8'hF4, rd);
        tests++; if (rd !== 8'h03) begin fails++; $display("FAIL reset_ctrl got %h exp 03", rd); end
        io_read(8'hF3, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL reset_rate got %h exp 00", rd); end
    endtask

    task automatic test_vblank();
        for (int i = 0; i < 4; i++) begin
            vb = 1; cyc();
            tests++; if (pending !== 2'b01) begin fails++; $display("FAIL vb%0d_pending got %b exp 01", i, pending); end
            tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL vb%0d_int_n_early got %b exp 1", i, int_n); end
            vb = 0; cyc();
            tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL vb%0d_int_n got %b exp 0", i, int_n); end
            ack();
            tests++; if (pending !== 2'b00) begin fails++; $display("FAIL vb%0d_ack_pending got %b exp 00", i, pending); end
            cyc();
            tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL vb%0d_ack_int_n got %b exp 1", i, int_n); end
        end
    endtask

    task automatic test_rate();
        int hits = 0;
        logic exp;
        io_write(8'hF3, 8'h01);
        io_read(8'hF3, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL rate_read got %h exp 01", rd); end
        for (int p = 1; p <= 8; p++) begin
            exp = (p % 4 == 0);
            vb = 1; cyc();
            tests++; if (pending[0] !== exp) begin fails++; $display("FAIL rate_pulse%0d got %b exp %b", p, pending[0], exp); end
            if (pending[0]) hits++;
            vb = 0; cyc(); ack();
        end
        tests++; if (hits != 2) begin fails++; $display("FAIL rate_hits got %0d exp 2", hits); end
    endtask

    task automatic test_keyboard();
        logic [7:0] seq [4] = '{8'h04, 8'h04, 8'h0C, 8'h00};
        logic       exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int sets = 0;
        vb = 1; cyc(); vb = 0; cyc();
        tests++; if (dut.u_div.cnt_q !== 6'd1) begin fails++; $display("FAIL kb_precnt got %0d exp 1", dut.u_div.cnt_q); end
        kb_mode = 1; kb_rows = 0; cyc();
        for (int i = 0; i < 4; i++) begin
            kb_rows = seq[i]; cyc();
            tests++; if (pending[1] !== exp[i]) begin fails++; $display("FAIL kb_step%0d got %b exp %b", i, pending[1], exp[i]); end
            if (pending[1]) sets++;
            ack();
        end
        tests++; if (sets != 2) begin fails++; $display("FAIL kb_sets got %0d exp 2", sets); end
        repeat (2) begin vb = 1; cyc(); vb = 0; cyc(); end
        tests++; if (dut.u_div.cnt_q !== 6'd1) begin fails++; $display("FAIL kb_cnt_hold got %0d exp 1", dut.u_div.cnt_q); end
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL kb_vb_masked got %b exp 00", pending); end
        kb_mode = 0; cyc();
    endtask

    task automatic test_ack_collision();
        io_write(8'hF3, 8'h00);
        tests++; if (dut.u_div.cnt_q !== 6'd0) begin fails++; $display("FAIL coll_restart got %0d exp 0", dut.u_div.cnt_q); end
        vb = 1; cyc(); vb = 0; cyc();
        tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL coll_pre_int_n got %b exp 0", int_n); end
        vb = 1; int_ack = 1; cyc(); int_ack = 0; vb = 0;
        tests++; if (pending[0] !== 1'b1) begin fails++; $display("FAIL coll_pending got %b exp 1", pending[0]); end
        cyc();
        tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL coll_int_n got %b exp 0", int_n); end
        ack(); cyc();
    endtask

    task automatic test_status_clear();
        vb = 1; cyc(); vb = 0;
        kb_mode = 1; kb_rows = 8'h01; cyc();
        kb_mode = 0; kb_rows = 8'h00;
        tests++; if (pending !== 2'b11) begin fails++; $display("FAIL st_setup got %b exp 11", pending); end
        io_write(8'hF5, 8'h02);
        tests++; if (pending !== 2'b01) begin fails++; $display("FAIL st_w1c got %b exp 01", pending); end
        cyc();
        tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL st_int_n got %b exp 0", int_n); end
        io_write(8'hF4, 8'h00); cyc();
        tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL st_masked_int_n got %b exp 1", int_n); end
        tests++; if (pending !== 2'b01) begin fails++; $display("FAIL st_masked_pending got %b exp 01", pending); end
        io_read(8'hF5, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL st_read got %h exp 01", rd); end
        io_write(8'hF4, 8'h03); io_write(8'hF5, 8'h03);
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL st_clear_all got %b exp 00", pending); end
        cyc();
    endtask

    task automatic test_cen();
        cen = 0; io_write(8'hF4, 8'h00); vb = 1; cyc(); vb = 0; cen = 1;
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL cen_pending got %b exp 00", pending); end
        io_read(8'hF4, rd);
        tests++; if (rd !== 8'h03) begin fails++; $display("FAIL cen_ctrl got %h exp 03", rd); end
        cyc();
    endtask

    task automatic test_reset_mid();
        io_write(8'hF3, 8'h03);
        repeat (2) begin vb = 1; cyc(); vb = 0; cyc(); end
        tests++; if (dut.u_div.cnt_q !== 6'd2) begin fails++; $display("FAIL mid_cnt got %0d exp 2", dut.u_div.cnt_q); end
        kb_mode = 1; kb_rows = 8'h02; cyc(); kb_mode = 0; kb_rows = 8'h00; cyc();
        io_read(8'hF4, rd);
        tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL mid_pre_int_n got %b exp 0", int_n); end
        cen = 0; reset = 1; cyc(); reset = 0; cen = 1;
        tests++; if (dut.u_div.cnt_q !== 6'd0) begin fails++; $display("FAIL mid_rst_cnt got %0d exp 0", dut.u_div.cnt_q); end
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL mid_rst_pending got %b exp 00", pending); end
        tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL mid_rst_int_n got %b exp 1", int_n); end
        tests++; if (io_dout !== 8'hFF) begin fails++; $display("FAIL mid_rst_dout got %h exp ff", io_dout); end
        io_read(8'hF3, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL mid_rst_rate got %h exp 00", rd); end
        io_read(8'hF4, rd);
        io_read(8'hF0, rd);
        tests++; if (rd !== 8'hFF) begin fails++; $display("FAIL unmapped_read got %h exp ff", rd); end
    endtask

    initial begin
        test_reset();
        test_vblank();
        test_rate();
        test_keyboard();
        test_ack_collision();
        test_status_clear();
        test_cen();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
